ibex_ex_ctrl: RTL
=================

IBEX_EX_CTRL -- requirements
Module: ibex_ex_ctrl

Interface
REQ-001 Parameters: RV32M, ibex_pkg::RV32MFast, selects multdiv support (RV32MNone disables it); RV32F, ibex_pkg::RV32FNone, selects FP support (RV32Fbfloat enables it).
REQ-002 clk_i  input  1  single clock; all state on rising edge.
REQ-003 rst_ni  input  1  reset, asynchronous and active-low.
REQ-004 instr_valid_i  input  1  decoder presents an instruction.
REQ-005 instr_ready_o  output  1  controller accepts the instruction this cycle.
REQ-006 instr_kind_i  input  2  instruction kind: 0 ALU, 1 MUL, 2 DIV, 3 FP.
REQ-007 rf_we_dec_i  input  1  instruction writes the register file.
REQ-008 rf_waddr_dec_i  input  5  destination register.
REQ-009 kill_i  input  1  flush of the in-flight instruction.
REQ-010 wb_stall_i  input  1  writeback port busy; completion is held.
REQ-011 mult_en_o, div_en_o, mult_sel_o, div_sel_o, fp_sel_o  output  1 each  EX-block unit enables and selects.
REQ-012 alu_instr_first_cycle_o  output  1  first EXEC cycle of the current instruction.
REQ-013 multdiv_ready_id_o  output  1  EX may finish a multdiv operation.
REQ-014 ex_valid_i  input  1  EX result valid.
REQ-015 result_ex_i  input  32  EX result.
REQ-016 imd_val_we_i  input  2  intermediate register write enables.
REQ-017 imd_val_d_i  input  2x34  intermediate register write data.
REQ-018 imd_val_q_o  output  2x34  intermediate register contents.
REQ-019 rf_we_o, rf_waddr_o[4:0], rf_wdata_o[31:0]  output  registered writeback port.

Function
REQ-020 FSM states: IDLE, EXEC.
REQ-021 instr_ready_o = (state==IDLE) | (state==EXEC & complete), where complete = ex_valid_i & ~wb_stall_i & ~kill_i.
REQ-022 Accept = instr_valid_i & instr_ready_o; on accept, capture kind, rf_we_dec_i, rf_waddr_dec_i and enter or stay in EXEC.
REQ-023 EXEC with complete and no accept -> IDLE; EXEC with kill_i -> IDLE, no writeback, kill takes priority over ex_valid_i.
REQ-024 alu_instr_first_cycle_o = 1 in the first cycle after accept only; 0 otherwise.
REQ-025 In EXEC: mult_sel_o=(kind==MUL), div_sel_o=(kind==DIV), fp_sel_o=(kind==FP); mult_en_o=mult_sel_o & ~kill_i, div_en_o=div_sel_o & ~kill_i; all 0 in IDLE.
REQ-026 RV32M==RV32MNone forces mult/div sel and en to 0; RV32F==RV32FNone forces fp_sel_o to 0; such instructions complete as ALU.
REQ-027 multdiv_ready_id_o = (state==EXEC) & ~wb_stall_i.
REQ-028 imd_val_q_o[k] <= imd_val_d_i[k] when state==EXEC & imd_val_we_i[k] & ~kill_i, each 34 bits, independent per k.
REQ-029 On kill_i or on accept, both imd registers clear to 0 next cycle.
REQ-030 On complete: next cycle rf_we_o = captured we & (waddr!=0), rf_waddr_o = captured waddr, rf_wdata_o = result_ex_i; rf_we_o is a 1-cycle pulse.
REQ-031 No complete: rf_we_o=0 next cycle; rf_waddr_o/rf_wdata_o hold.
REQ-032 ex_valid_i in IDLE is ignored.
REQ-033 wb_stall_i with ex_valid_i: remain in EXEC, ex_valid_i sampled again each cycle until stall drops.

Reset
REQ-034 rst_ni low: state IDLE, all enables/selects 0, alu_instr_first_cycle_o 0, imd_val_q_o 0, rf_we_o 0, rf_waddr_o 0, rf_wdata_o 0, captured fields 0.
REQ-035 Reset asserted mid-EXEC aborts without writeback; instr_ready_o=1 in first cycle after release.

Verification
REQ-036 ALU add, waddr=5, ex_valid_i in first EXEC cycle, result 0x0000_0007 -> rf_we_o pulse 1 cycle later with waddr 5, wdata 7; next instruction accepted same cycle.
REQ-037 DIV, ex_valid_i after 34 cycles with imd writes each cycle -> div_en_o high 34 cycles, imd_val_q_o tracks imd_val_d_i, single writeback.
REQ-038 MUL with kill_i on cycle 2 coincident with ex_valid_i -> no rf_we_o, state IDLE, imd_val_q_o 0.
REQ-039 ex_valid_i with wb_stall_i high 3 cycles -> writeback 1 cycle after stall drops, exactly once.
REQ-040 ALU to waddr=0 with rf_we_dec_i=1 -> rf_we_o stays 0.
REQ-041 rst_ni pulsed low mid-DIV -> all outputs reset values asynchronously, no writeback after release.

Source files
------------

// File: rtl/ibex_ex_ctrl.sv
// Execute-stage controller: takes one decoded instruction at a time, steers the EX units,
// holds the multdiv intermediate registers and drives a registered writeback port.
package ibex_pkg;
  typedef enum integer {
    RV32MNone        = 0,
    RV32MSlow        = 1,
    RV32MFast        = 2,
    RV32MSingleCycle = 3
  } rv32m_e;

  typedef enum integer {
    RV32FNone   = 0,
    RV32Fbfloat = 1
  } rv32f_e;
endpackage

module ibex_ex_ctrl #(
  parameter ibex_pkg::rv32m_e RV32M = ibex_pkg::RV32MFast,
  parameter ibex_pkg::rv32f_e RV32F = ibex_pkg::RV32FNone
) (
  input  logic        clk_i,
  input  logic        rst_ni,

  input  logic        instr_valid_i,
  output logic        instr_ready_o,
  input  logic [1:0]  instr_kind_i,
  input  logic        rf_we_dec_i,
  input  logic [4:0]  rf_waddr_dec_i,
  input  logic        kill_i,
  input  logic        wb_stall_i,

  output logic        mult_en_o,
  output logic        div_en_o,
  output logic        mult_sel_o,
  output logic        div_sel_o,
  output logic        fp_sel_o,
  output logic        alu_instr_first_cycle_o,
  output logic        multdiv_ready_id_o,

  input  logic        ex_valid_i,
  input  logic [31:0] result_ex_i,
  input  logic [1:0]  imd_val_we_i,
  input  logic [33:0] imd_val_d_i [2],
  output logic [33:0] imd_val_q_o [2],

  output logic        rf_we_o,
  output logic [4:0]  rf_waddr_o,
  output logic [31:0] rf_wdata_o
);

  localparam bit MultDivEn = (RV32M != ibex_pkg::RV32MNone);
  localparam bit FpEn      = (RV32F != ibex_pkg::RV32FNone);

  typedef enum logic {StIdle, StExec} state_e;

  localparam logic [1:0] KindMul = 2'd1;
  localparam logic [1:0] KindDiv = 2'd2;
  localparam logic [1:0] KindFp  = 2'd3;

  state_e      state_q, state_d;
  logic [1:0]  kind_q;
  logic        we_q;
  logic [4:0]  waddr_q;
  logic        first_q;
  logic [33:0] imd_q [2];
  logic        rf_we_q;
  logic [4:0]  rf_waddr_q;
  logic [31:0] rf_wdata_q;

  logic in_exec;
  logic complete;
  logic accept;

  assign in_exec  = (state_q == StExec);
  // Kill outranks a coincident ex_valid_i; a held writeback port delays completion.
  assign complete = in_exec & ex_valid_i & ~wb_stall_i & ~kill_i;
  assign instr_ready_o = ~in_exec | complete;
  assign accept   = instr_valid_i & instr_ready_o;

  always_comb begin
    state_d = state_q;
    if (accept) begin
      state_d = StExec;
    end else if (in_exec && (complete || kill_i)) begin
      state_d = StIdle;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= StIdle;
      kind_q     <= 2'd0;
      we_q       <= 1'b0;
      waddr_q    <= 5'd0;
      first_q    <= 1'b0;
      imd_q[0]   <= 34'd0;
      imd_q[1]   <= 34'd0;
      rf_we_q    <= 1'b0;
      rf_waddr_q <= 5'd0;
      rf_wdata_q <= 32'd0;
    end else begin
      state_q <= state_d;
      first_q <= accept;
      if (accept) begin
        kind_q  <= instr_kind_i;
        we_q    <= rf_we_dec_i;
        waddr_q <= rf_waddr_dec_i;
      end
      for (int k = 0; k < 2; k++) begin
        if (accept || kill_i) begin
          imd_q[k] <= 34'd0;
        end else if (in_exec && imd_val_we_i[k]) begin
          imd_q[k] <= imd_val_d_i[k];
        end
      end
      rf_we_q <= 1'b0;
      if (complete) begin
        rf_we_q    <= we_q & (waddr_q != 5'd0);
        rf_waddr_q <= waddr_q;
        rf_wdata_q <= result_ex_i;
      end
    end
  end

  // Unsupported extensions fall back to plain ALU completion: selects stay low.
  always_comb begin
    mult_sel_o = 1'b0;
    div_sel_o  = 1'b0;
    fp_sel_o   = 1'b0;
    if (in_exec) begin
      mult_sel_o = MultDivEn & (kind_q == KindMul);
      div_sel_o  = MultDivEn & (kind_q == KindDiv);
      fp_sel_o   = FpEn & (kind_q == KindFp);
    end
  end

  assign mult_en_o               = mult_sel_o & ~kill_i;
  assign div_en_o                = div_sel_o & ~kill_i;
  assign alu_instr_first_cycle_o = first_q;
  assign multdiv_ready_id_o      = in_exec & ~wb_stall_i;
  assign imd_val_q_o[0]          = imd_q[0];
  assign imd_val_q_o[1]          = imd_q[1];
  assign rf_we_o                 = rf_we_q;
  assign rf_waddr_o              = rf_waddr_q;
  assign rf_wdata_o              = rf_wdata_q;

endmodule
